// File: rtl/datapath_pkg.sv
// Shared constants for the parametrised accumulator datapath:
// bus source selects, ALU opcodes and the multiply sequencer states.
package datapath_pkg;

  localparam logic [3:0] BUS_ZERO = 4'd0;
  localparam logic [3:0] BUS_AR   = 4'd1;
  localparam logic [3:0] BUS_PC   = 4'd2;
  localparam logic [3:0] BUS_IR   = 4'd3;
  localparam logic [3:0] BUS_DR   = 4'd4;
  localparam logic [3:0] BUS_REG  = 4'd5;
  localparam logic [3:0] BUS_AC   = 4'd6;
  localparam logic [3:0] BUS_DRAM = 4'd7;
  localparam logic [3:0] BUS_IRAM = 4'd8;

  localparam logic [2:0] OP_PASS = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_INC  = 3'd5;
  localparam logic [2:0] OP_CLR  = 3'd6;
  localparam logic [2:0] OP_MUL  = 3'd7;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_RUN  = 1'b1
  } mul_state_e;

endpackage

// File: rtl/datapath_param_alu_seq.sv
// AC register, single-cycle ALU with Z/C flags, and the
// shift-add multiply sequencer with busy/done handshake.
module alu_seq
  import datapath_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] ac_o,
  output logic             z_o,
  output logic             c_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  mul_state_e       state_q;
  logic [WIDTH-1:0] ac_q;
  logic             z_q;
  logic             c_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] prod_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   res_d;
  logic [WIDTH-1:0] prod_d;

  // Bit WIDTH of the widened result is carry-out, or borrow for SUB.
  always_comb begin
    res_d = '0;
    unique case (op_i)
      OP_PASS: res_d = {1'b0, b_i};
      OP_ADD:  res_d = {1'b0, ac_q} + {1'b0, b_i};
      OP_SUB:  res_d = {1'b0, ac_q} - {1'b0, b_i};
      OP_AND:  res_d = {1'b0, ac_q & b_i};
      OP_OR:   res_d = {1'b0, ac_q | b_i};
      OP_INC:  res_d = {1'b0, ac_q} + {{WIDTH{1'b0}}, 1'b1};
      OP_CLR:  res_d = '0;
      OP_MUL:  res_d = '0;
    endcase
  end

  always_comb begin
    prod_d = prod_q;
    if (mplier_q[0]) prod_d = prod_q + mcand_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= MUL_IDLE;
      ac_q     <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        MUL_IDLE: begin
          if (start_i && op_i == OP_MUL) begin
            mcand_q  <= ac_q;
            mplier_q <= b_i;
            prod_q   <= '0;
            cnt_q    <= CW'(WIDTH);
            state_q  <= MUL_RUN;
          end else if (start_i) begin
            ac_q <= res_d[WIDTH-1:0];
            z_q  <= (res_d[WIDTH-1:0] == '0);
            c_q  <= res_d[WIDTH];
          end
        end
        MUL_RUN: begin
          prod_q   <= prod_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CW'(1);
          busy_q   <= (cnt_q != CW'(1));
          if (cnt_q == CW'(1)) begin
            ac_q    <= prod_d;
            z_q     <= (prod_d == '0);
            c_q     <= 1'b0;
            done_q  <= 1'b1;
            state_q <= MUL_IDLE;
          end
        end
      endcase
    end
  end

  assign ac_o   = ac_q;
  assign z_o    = z_q;
  assign c_o    = c_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: rtl/datapath_param.sv
// Shared-bus accumulator datapath: AR/PC/DR/IR, register file,
// bus mux and PC logic; AC and multiply live in alu_seq.
module datapath_param
  import datapath_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 4,
  localparam int RSW = $clog2(NREGS)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] dram_in,
  input  logic [WIDTH-1:0] iram_in,
  input  logic [3:0]       bus_sel,
  input  logic [RSW-1:0]   reg_sel,
  input  logic             ld_reg,
  input  logic             ld_ar,
  input  logic             ld_dr,
  input  logic             ld_ir,
  input  logic             ld_pc,
  input  logic             inc_pc,
  input  logic             alu_start,
  input  logic [2:0]       alu_op,
  output logic [WIDTH-1:0] bus_out,
  output logic [WIDTH-1:0] addr_out,
  output logic [WIDTH-1:0] ir_out,
  output logic             z_flag,
  output logic             c_flag,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] ar_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] dr_q;
  logic [WIDTH-1:0] ir_q;
  logic [WIDTH-1:0] rf_q [NREGS];
  logic [WIDTH-1:0] ac;

  always_comb begin
    bus_out = '0;
    unique case (bus_sel)
      BUS_AR:   bus_out = ar_q;
      BUS_PC:   bus_out = pc_q;
      BUS_IR:   bus_out = ir_q;
      BUS_DR:   bus_out = dr_q;
      BUS_REG:  bus_out = rf_q[reg_sel];
      BUS_AC:   bus_out = ac;
      BUS_DRAM: bus_out = dram_in;
      BUS_IRAM: bus_out = iram_in;
      default:  bus_out = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ar_q <= '0;
      pc_q <= '0;
      dr_q <= '0;
      ir_q <= '0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      if (ld_ar) ar_q <= bus_out;
      if (ld_dr) dr_q <= bus_out;
      if (ld_ir) ir_q <= bus_out;
      if (ld_reg) rf_q[reg_sel] <= bus_out;
      if (ld_pc) pc_q <= bus_out;
      else if (inc_pc) pc_q <= pc_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  alu_seq #(
    .WIDTH(WIDTH)
  ) u_alu (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .start_i(alu_start),
    .op_i   (alu_op),
    .b_i    (bus_out),
    .ac_o   (ac),
    .z_o    (z_flag),
    .c_o    (c_flag),
    .busy_o (busy),
    .done_o (done)
  );

  assign addr_out = ar_q;
  assign ir_out   = ir_q;

endmodule

// File: tb/tb_datapath_param.sv
// Directed vector bench for datapath_param (WIDTH=16, NREGS=4).
module tb_datapath_param;
  import datapath_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] dram_in, iram_in;
  logic [3:0]  bus_sel;
  logic [1:0]  reg_sel;
  logic        ld_reg, ld_ar, ld_dr, ld_ir, ld_pc, inc_pc;
  logic        alu_start;
  logic [2:0]  alu_op;
  logic [15:0] bus_out, addr_out, ir_out;
  logic        z_flag, c_flag, busy, done;

  int n_vec = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  datapath_param #(.WIDTH(16), .NREGS(4)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .dram_in  (dram_in),
    .iram_in  (iram_in),
    .bus_sel  (bus_sel),
    .reg_sel  (reg_sel),
    .ld_reg   (ld_reg),
    .ld_ar    (ld_ar),
    .ld_dr    (ld_dr),
    .ld_ir    (ld_ir),
    .ld_pc    (ld_pc),
    .inc_pc   (inc_pc),
    .alu_start(alu_start),
    .alu_op   (alu_op),
    .bus_out  (bus_out),
    .addr_out (addr_out),
    .ir_out   (ir_out),
    .z_flag   (z_flag),
    .c_flag   (c_flag),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    logic [3:0]  sel;
    logic [15:0] dram;
    logic [15:0] iram;
    logic        ldir, ldar, ldpc, incpc, st;
    logic [2:0]  op;
    logic [15:0] e_ac;
    logic        e_z, e_c;
    logic [15:0] e_pc, e_ar, e_ir;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string nm, input logic [15:0] a,
                     input logic [15:0] e);
    n_vec++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_strobes();
    ld_reg = 0; ld_ar = 0; ld_dr = 0; ld_ir = 0;
    ld_pc = 0; inc_pc = 0; alu_start = 0;
  endtask

  task automatic peek(input logic [3:0] s, input logic [1:0] r,
                      output logic [15:0] v);
    bus_sel = s;
    reg_sel = r;
    #1;
    v = bus_out;
  endtask

  task automatic alu(input logic [2:0] op, input logic [15:0] d);
    bus_sel = BUS_DRAM;
    dram_in = d;
    alu_op = op;
    alu_start = 1;
    step();
    alu_start = 0;
  endtask

  logic [15:0] v;
  int bc, dc, dk;

  initial begin
    reset_n = 0;
    dram_in = 0; iram_in = 0;
    bus_sel = 0; reg_sel = 0; alu_op = 0;
    clr_strobes();

    vt[0]  = '{BUS_IRAM, 16'h0000, 16'h1234, 1,0,0,0,0, OP_PASS,
               16'h0000, 0,0, 16'h0000, 16'h0000, 16'h1234};
    vt[1]  = '{BUS_DRAM, 16'h00FF, 16'h0000, 0,1,1,1,0, OP_PASS,
               16'h0000, 0,0, 16'h00FF, 16'h00FF, 16'h1234};
    vt[2]  = '{BUS_DRAM, 16'hFFFF, 16'h0000, 0,0,1,0,0, OP_PASS,
               16'h0000, 0,0, 16'hFFFF, 16'h00FF, 16'h1234};
    vt[3]  = '{BUS_ZERO, 16'h0000, 16'h0000, 0,0,0,1,0, OP_PASS,
               16'h0000, 0,0, 16'h0000, 16'h00FF, 16'h1234};
    vt[4]  = '{BUS_DRAM, 16'hFFFF, 16'h0000, 0,0,0,0,1, OP_PASS,
               16'hFFFF, 0,0, 16'h0000, 16'h00FF, 16'h1234};
    vt[5]  = '{BUS_DRAM, 16'h0001, 16'h0000, 0,0,0,0,1, OP_ADD,
               16'h0000, 1,1, 16'h0000, 16'h00FF, 16'h1234};
    vt[6]  = '{BUS_DRAM, 16'h0001, 16'h0000, 0,0,0,0,1, OP_SUB,
               16'hFFFF, 0,1, 16'h0000, 16'h00FF, 16'h1234};
    vt[7]  = '{BUS_DRAM, 16'h0F0F, 16'h0000, 0,0,0,0,1, OP_AND,
               16'h0F0F, 0,0, 16'h0000, 16'h00FF, 16'h1234};
    vt[8]  = '{BUS_DRAM, 16'hF000, 16'h0000, 0,0,0,0,1, OP_OR,
               16'hFF0F, 0,0, 16'h0000, 16'h00FF, 16'h1234};
    vt[9]  = '{BUS_ZERO, 16'h0000, 16'h0000, 0,0,0,0,1, OP_INC,
               16'hFF10, 0,0, 16'h0000, 16'h00FF, 16'h1234};
    vt[10] = '{BUS_ZERO, 16'h0000, 16'h0000, 0,0,0,0,1, OP_CLR,
               16'h0000, 1,0, 16'h0000, 16'h00FF, 16'h1234};
    vt[11] = '{BUS_ZERO, 16'h0000, 16'h0000, 0,0,0,0,1, OP_INC,
               16'h0001, 0,0, 16'h0000, 16'h00FF, 16'h1234};
    vt[12] = '{BUS_DRAM, 16'h0005, 16'h0000, 0,0,0,0,1, OP_SUB,
               16'hFFFC, 0,1, 16'h0000, 16'h00FF, 16'h1234};
    vt[13] = '{BUS_DRAM, 16'hFFFC, 16'h0000, 0,0,0,0,1, OP_SUB,
               16'h0000, 1,0, 16'h0000, 16'h00FF, 16'h1234};

    // reset state
    step();
    reset_n = 1;
    peek(BUS_PC, 0, v);
    chk("rst_pc_bus", v, 16'h0000);
    chk("rst_addr", addr_out, 16'h0000);
    chk("rst_ir", ir_out, 16'h0000);
    chk("rst_flags", {z_flag, c_flag, busy, done}, 16'h0);

    foreach (vt[i]) begin
      bus_sel = vt[i].sel;
      dram_in = vt[i].dram;
      iram_in = vt[i].iram;
      ld_ir = vt[i].ldir;
      ld_ar = vt[i].ldar;
      ld_pc = vt[i].ldpc;
      inc_pc = vt[i].incpc;
      alu_start = vt[i].st;
      alu_op = vt[i].op;
      step();
      clr_strobes();
      peek(BUS_AC, 0, v);
      chk($sformatf("v%0d_ac", i), v, vt[i].e_ac);
      peek(BUS_PC, 0, v);
      chk($sformatf("v%0d_pc", i), v, vt[i].e_pc);
      chk($sformatf("v%0d_z", i), z_flag, vt[i].e_z);
      chk($sformatf("v%0d_c", i), c_flag, vt[i].e_c);
      chk($sformatf("v%0d_ar", i), addr_out, vt[i].e_ar);
      chk($sformatf("v%0d_ir", i), ir_out, vt[i].e_ir);
    end

    // DR, register file, bus sources
    bus_sel = BUS_DRAM; dram_in = 16'hA5A5; ld_dr = 1;
    step(); clr_strobes();
    peek(BUS_DR, 0, v);
    chk("dr_load", v, 16'hA5A5);
    bus_sel = BUS_DRAM; dram_in = 16'hBEEF; reg_sel = 3; ld_reg = 1;
    step(); clr_strobes();
    peek(BUS_REG, 3, v);
    chk("reg3", v, 16'hBEEF);
    peek(BUS_REG, 0, v);
    chk("reg0", v, 16'h0000);
    // same-index write/read: bus shows old value during the write
    bus_sel = BUS_DRAM; dram_in = 16'h1111; ld_reg = 1; reg_sel = 2;
    step(); clr_strobes();
    bus_sel = BUS_REG; reg_sel = 2; dram_in = 16'h0000;
    ld_reg = 1; reg_sel = 2;
    #1;
    chk("reg_rw_old", bus_out, 16'h1111);
    step(); clr_strobes();
    peek(BUS_IR, 0, v);
    chk("bus_ir", v, 16'h1234);
    peek(4'd12, 0, v);
    chk("bus_sel12", v, 16'h0000);

    // multiply 7 x 6, mid-run start ignored, PC still moves
    alu(OP_PASS, 16'h0007);
    peek(BUS_PC, 0, v);
    chk("pc_pre_mul", v, 16'h0000);
    alu(OP_MUL, 16'h0006);
    chk("mul_busy_s", busy, 16'h0);
    bc = 0; dc = 0; dk = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) begin
        bus_sel = BUS_DRAM; dram_in = 16'h0006;
        alu_start = 1; alu_op = OP_ADD; inc_pc = 1;
      end
      step();
      clr_strobes();
      if (busy) bc++;
      if (done) begin dc++; dk = k; end
      if (k == 5) begin
        peek(BUS_AC, 0, v);
        chk("mul_ac_held", v, 16'h0007);
      end
    end
    chk("mul_busy_cyc", bc[15:0], 16'd15);
    chk("mul_done_cnt", dc[15:0], 16'd1);
    chk("mul_done_edge", dk[15:0], 16'd16);
    peek(BUS_AC, 0, v);
    chk("mul_ac", v, 16'h002A);
    chk("mul_zc", {z_flag, c_flag}, 16'h0);
    peek(BUS_PC, 0, v);
    chk("mul_pc_inc", v, 16'h0001);

    // 0x8000 x 2 wraps to zero; C held at 1 during the run
    alu(OP_PASS, 16'hFFFF);
    alu(OP_ADD, 16'h8001);
    chk("pre_mul2_c", c_flag, 16'h1);
    alu(OP_MUL, 16'h0002);
    dk = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 8) chk("mul2_c_held", c_flag, 16'h1);
      if (done && dk == 0) dk = k;
    end
    chk("mul2_done_edge", dk[15:0], 16'd16);
    peek(BUS_AC, 0, v);
    chk("mul2_ac", v, 16'h0000);
    chk("mul2_zc", {z_flag, c_flag}, 16'h2);

    // reset in the middle of a multiply
    alu(OP_PASS, 16'h0007);
    alu(OP_MUL, 16'h0006);
    for (int k = 1; k <= 4; k++) step();
    chk("rm_busy_pre", busy, 16'h1);
    reset_n = 0;
    step();
    reset_n = 1;
    chk("rm_busy", busy, 16'h0);
    dc = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (done) dc++;
    end
    chk("rm_no_done", dc[15:0], 16'd0);
    peek(BUS_AC, 0, v);
    chk("rm_ac", v, 16'h0000);
    peek(BUS_REG, 3, v);
    chk("rm_reg3", v, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
